// File: rtl/param_instr_mem.sv
// Parameterised instruction memory: zero-fill sweep after reset, program-load
// write port and a stallable read pipeline of depth RD_LAT (1 or 2).
module param_instr_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_in_range_s;
    logic              wr_in_range_s;
    logic              rd_accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    logic [DATA_W-1:0] s1_data_q;
    logic              s1_valid_q;
    logic              s1_err_q;

    // Widen both sides by one bit so DEPTH == 2**ADDR_W still compares correctly.
    assign rd_in_range_s = ({1'b0, addr} < DEPTH_L);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_accept_s   = (state_q == READY) && rd_en && !stall;

    // The sweep owns the write port while clearing; port writes are only taken in READY.
    assign mem_we_s    = !reset && ((state_q == CLEAR) || (wr_en && wr_in_range_s));
    assign mem_waddr_s = (state_q == CLEAR) ? ptr_q : wr_addr;
    assign mem_wdata_s = (state_q == CLEAR) ? {DATA_W{1'b0}} : wr_data;

    // Clear-sweep FSM: one word per cycle from pointer 0 to DEPTH-1, then READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= READY;
                        ptr_q   <= {ADDR_W{1'b0}};
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q   <= ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= CLEAR;
                    ptr_q   <= {ADDR_W{1'b0}};
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array; a read in the same cycle sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s[IDX_W-1:0]] <= mem_wdata_s;
        end
    end

    // First read stage: out-of-range reads return zero and flag addr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q  <= {DATA_W{1'b0}};
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= rd_accept_s;
            s1_err_q   <= rd_accept_s && !rd_in_range_s;
            if (rd_accept_s) begin
                s1_data_q <= rd_in_range_s ? mem[addr[IDX_W-1:0]] : {DATA_W{1'b0}};
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_q;
            logic              s2_valid_q;
            logic              s2_err_q;

            // Output stage; bubbles keep the last word on out.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_data_q  <= {DATA_W{1'b0}};
                    s2_valid_q <= 1'b0;
                    s2_err_q   <= 1'b0;
                end else if (!stall) begin
                    s2_valid_q <= s1_valid_q;
                    s2_err_q   <= s1_err_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign out       = s2_data_q;
            assign out_valid = s2_valid_q;
            assign addr_err  = s2_err_q;
        end else begin : g_lat1
            assign out       = s1_data_q;
            assign out_valid = s1_valid_q;
            assign addr_err  = s1_err_q;
        end
    endgenerate

    assign busy = busy_q;

endmodule

// File: tb/tb_param_instr_mem.sv
// Scoreboard bench for param_instr_mem: two instances (256/lat1 and 200/lat2)
// share random stimulus; a high-level model predicts results per instance.
module tb_param_instr_mem;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset   = 1'b1;
    logic        rd_en   = 1'b0;
    logic [7:0]  addr    = 8'd0;
    logic        stall   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [7:0]  wr_addr = 8'd0;
    logic [31:0] wr_data = 32'd0;

    logic [31:0] dout  [NI];
    logic        dval  [NI];
    logic        derr  [NI];
    logic        dbusy [NI];

    param_instr_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .rd_en(rd_en), .addr(addr), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(dout[0]), .out_valid(dval[0]), .addr_err(derr[0]), .busy(dbusy[0]));

    param_instr_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(2)) u_b (
        .clk(clk), .reset(reset), .rd_en(rd_en), .addr(addr), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(dout[1]), .out_valid(dval[1]), .addr_err(derr[1]), .busy(dbusy[1]));

    int depth_c [NI] = '{256, 200};
    int lat_c   [NI] = '{1, 2};

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          rem;
        int          edge_n;
    } rd_t;

    typedef struct {
        int   edge_n;
        logic busy;
    } bz_t;

    rd_t  infl [NI][$];
    rd_t  sbq  [NI][$];
    bz_t  bzq  [NI][$];

    logic [31:0] mmem    [NI][256];
    logic        m_ready [NI];
    int          sweep_n [NI];

    int errors   = 0;
    int checks   = 0;
    int edge_cnt = 0;

    logic rst_seen   = 1'b1;
    logic stall_seen = 1'b0;
    logic [31:0] pout [NI] = '{32'd0, 32'd0};
    logic        pval [NI] = '{1'b0, 1'b0};
    logic        perr [NI] = '{1'b0, 1'b0};

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] edge %0d: got %h expected %h", name, inst, edge_cnt, act, exp);
        end
    endtask

    always @(posedge clk) begin
        edge_cnt   <= edge_cnt + 1;
        rst_seen   <= reset;
        stall_seen <= stall;
    end

    // Monitor: pops expected reads / busy values and compares once per cycle.
    always @(negedge clk) begin
        rd_t mr;
        bz_t mb;
        for (int i = 0; i < NI; i++) begin
            if (bzq[i].size() > 0 && bzq[i][0].edge_n == edge_cnt) begin
                mb = bzq[i].pop_front();
                chk("busy", i, 32'(dbusy[i]), 32'(mb.busy));
            end
            if (rst_seen) begin
                chk("rst_out", i, dout[i], 32'd0);
                chk("rst_valid", i, 32'(dval[i]), 32'd0);
                chk("rst_err", i, 32'(derr[i]), 32'd0);
            end else if (stall_seen) begin
                chk("hold_out", i, dout[i], pout[i]);
                chk("hold_valid", i, 32'(dval[i]), 32'(pval[i]));
                chk("hold_err", i, 32'(derr[i]), 32'(perr[i]));
            end else if (dval[i]) begin
                if (sbq[i].size() == 0) begin
                    chk("unexp_valid", i, 32'(dval[i]), 32'd0);
                end else begin
                    mr = sbq[i].pop_front();
                    chk("rd_edge", i, 32'(edge_cnt), 32'(mr.edge_n));
                    chk("rd_data", i, dout[i], mr.data);
                    chk("rd_err", i, 32'(derr[i]), 32'(mr.err));
                end
            end else begin
                chk("bubble_err", i, 32'(derr[i]), 32'd0);
                chk("bubble_out", i, dout[i], pout[i]);
                if (sbq[i].size() > 0 && sbq[i][0].edge_n <= edge_cnt) begin
                    mr = sbq[i].pop_front();
                    chk("missing_valid", i, 32'(dval[i]), 32'd1);
                end
            end
            pout[i] <= dout[i];
            pval[i] <= dval[i];
            perr[i] <= derr[i];
        end
    end

    // Drive one cycle and advance the reference model for the edge that samples it.
    task automatic step(input logic rst, input logic rd, input logic [7:0] a,
                        input logic st, input logic we, input logic [7:0] wa,
                        input logic [31:0] wd);
        int  k;
        rd_t e;
        bz_t b;
        @(negedge clk);
        #1;
        reset = rst; rd_en = rd; addr = a; stall = st;
        wr_en = we; wr_addr = wa; wr_data = wd;
        k = edge_cnt + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                infl[i].delete();
                m_ready[i] = 1'b0;
                sweep_n[i] = 0;
            end else begin
                if (!st) begin
                    for (int j = 0; j < infl[i].size(); j++) infl[i][j].rem = infl[i][j].rem - 1;
                end
                if (m_ready[i] && rd && !st) begin
                    e.err    = (int'(a) >= depth_c[i]);
                    e.data   = e.err ? 32'd0 : mmem[i][a];
                    e.rem    = lat_c[i] - 1;
                    e.edge_n = 0;
                    infl[i].push_back(e);
                end
                while (infl[i].size() > 0 && infl[i][0].rem <= 0) begin
                    e = infl[i].pop_front();
                    e.edge_n = k;
                    sbq[i].push_back(e);
                end
                if (m_ready[i] && we && int'(wa) < depth_c[i]) mmem[i][wa] = wd;
                if (!m_ready[i]) begin
                    sweep_n[i]++;
                    if (sweep_n[i] == depth_c[i]) begin
                        m_ready[i] = 1'b1;
                        for (int j = 0; j < 256; j++) mmem[i][j] = 32'd0;
                    end
                end
            end
            b.edge_n = k;
            b.busy   = !m_ready[i];
            bzq[i].push_back(b);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b1, a, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, a, d);
    endtask

    task automatic sweep_with_noise(input int n);
        for (int c = 0; c < n; c++)
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0,
                 1'($urandom_range(0, 1)), 8'($urandom), 32'hFFFF_FFFF);
    endtask

    initial begin
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        sweep_with_noise(260);

        wr(8'd0, 32'h7104_1000);
        wr(8'd3, 32'h4142_0C00);
        rd(8'd0); rd(8'd1); rd(8'd3);
        idle(3);

        rd(8'd3);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        idle(3);

        rd(8'd200); rd(8'd255); rd(8'd199);
        wr(8'd220, 32'hDEAD_BEEF);
        rd(8'd220); rd(8'd0); rd(8'd3);
        idle(3);

        wr(8'd5, 32'hAAAA_AAAA);
        step(1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 8'd5, 32'h5555_5555);
        rd(8'd5);
        idle(3);

        for (int c = 0; c < 3000; c++)
            step(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 8'($urandom), $urandom);
        sweep_with_noise(260);

        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        sweep_with_noise(100);
        step(1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 8'd0, 32'd0);
        sweep_with_noise(260);
        for (int c = 0; c < 40; c++) rd(8'($urandom));
        idle(6);

        for (int i = 0; i < NI; i++) chk("drain", i, 32'(sbq[i].size() + infl[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
